// File: rtl/palindrome_pkg.sv
// Shared widths, FSM encoding and decimal helpers for the palindrome builder.
package palindrome_pkg;
    localparam int SEED_W   = 8;
    localparam int RESULT_W = 20;
    localparam int ND_W     = 3;

    localparam logic [SEED_W-1:0] DEC_TEN     = 8'd10;
    localparam logic [SEED_W-1:0] DEC_HUNDRED = 8'd100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of decimal digits in an 8-bit value; zero counts as one digit.
    function automatic logic [1:0] digit_count(input logic [SEED_W-1:0] v);
        if (v < DEC_TEN) begin
            return 2'd1;
        end else if (v < DEC_HUNDRED) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction
endpackage

// File: rtl/dec_digit_split.sv
// Combinational split of an 8-bit value into its last decimal digit and the rest.
module dec_digit_split
    import palindrome_pkg::*;
(
    input  logic [SEED_W-1:0] i_value,
    output logic [SEED_W-1:0] o_quot,
    output logic [3:0]        o_rem
);
    assign o_quot = i_value / DEC_TEN;
    assign o_rem  = 4'(i_value - o_quot * DEC_TEN);
endmodule

// File: rtl/palindrome_builder.sv
// Builds a decimal palindrome from an 8-bit seed, appending one mirrored digit per clock.
module palindrome_builder
    import palindrome_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [SEED_W-1:0]   seed,
    input  logic                odd_mode,
    output logic                busy,
    output logic                done,
    output logic [RESULT_W-1:0] result,
    output logic [ND_W-1:0]     num_digits
);
    state_t              r_state;
    state_t              w_state_nxt;
    logic [RESULT_W-1:0] r_result;
    logic [SEED_W-1:0]   r_temp;
    logic [1:0]          r_cnt;
    logic [ND_W-1:0]     r_nd;

    logic                w_accept;
    logic [1:0]          w_digits;
    logic [1:0]          w_iters;
    logic [ND_W-1:0]     w_nd;
    logic [SEED_W-1:0]   w_temp_quot;
    logic [3:0]          w_temp_digit;
    logic [SEED_W-1:0]   w_seed_quot;
    logic [3:0]          w_seed_rem_unused;
    logic [RESULT_W-1:0] w_step;

    dec_digit_split u_split_temp (
        .i_value (r_temp),
        .o_quot  (w_temp_quot),
        .o_rem   (w_temp_digit)
    );

    // Odd mode drops the centre digit, so the mirror starts from seed/10.
    dec_digit_split u_split_seed (
        .i_value (seed),
        .o_quot  (w_seed_quot),
        .o_rem   (w_seed_rem_unused)
    );

    assign w_accept = start && (r_state != BUILD);
    assign w_digits = digit_count(seed);
    assign w_iters  = odd_mode ? (w_digits - 2'd1) : w_digits;
    assign w_nd     = odd_mode ? ({w_digits, 1'b0} - 3'd1) : {w_digits, 1'b0};
    assign w_step   = (r_result << 3) + (r_result << 1)
                    + {{(RESULT_W-4){1'b0}}, w_temp_digit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_state_nxt = (w_iters != 2'd0) ? BUILD : DONE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUILD: begin
                if (r_cnt == 2'd1) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == BUILD);
        done = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_temp   <= '0;
            r_cnt    <= '0;
            r_nd     <= '0;
        end else if (w_accept) begin
            r_result <= {{(RESULT_W-SEED_W){1'b0}}, seed};
            r_temp   <= odd_mode ? w_seed_quot : seed;
            r_cnt    <= w_iters;
            r_nd     <= w_nd;
        end else if (r_state == BUILD) begin
            r_result <= w_step;
            r_temp   <= w_temp_quot;
            r_cnt    <= r_cnt - 2'd1;
        end
    end

    assign result     = r_result;
    assign num_digits = r_nd;
endmodule

// File: tb/tb_palindrome_builder.sv
// Scoreboard bench for palindrome_builder with a string-based decimal reference model.
module tb_palindrome_builder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  seed = 8'd0;
    logic        odd_mode = 1'b0;
    logic        busy;
    logic        done;
    logic [19:0] result;
    logic [2:0]  num_digits;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int unsigned res;
        int unsigned nd;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    palindrome_builder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seed       (seed),
        .odd_mode   (odd_mode),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .num_digits (num_digits)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: write the seed in decimal and append its digits in reverse.
    function automatic void ref_model(input int s, input bit odd,
                                      output int unsigned res, output int unsigned nd,
                                      output int n);
        string ds;
        string p;
        int    last;
        ds   = $sformatf("%0d", s);
        p    = ds;
        last = odd ? ds.len() - 2 : ds.len() - 1;
        for (int i = last; i >= 0; i--) p = {p, ds.substr(i, i)};
        res = p.atoi();
        nd  = p.len();
        n   = p.len() - ds.len();
    endfunction

    function automatic bit is_pal(input int unsigned v);
        string s;
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len() / 2; i++)
            if (s.getc(i) != s.getc(s.len() - 1 - i)) return 1'b0;
        return 1'b1;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("result", result, mon_e.res);
                check("num_digits", num_digits, mon_e.nd);
                check("done_latency_cycle", cyc, mon_e.cyc);
                check("checker_palindrome", is_pal(result), 1);
            end
        end
    end

    task automatic run_one(input int s, input bit odd, input int gap);
        int unsigned r;
        int unsigned nd;
        int          n;
        int          nb;
        bit          got;
        ref_model(s, odd, r, nd, n);
        @(negedge clk);
        start = 1'b1; seed = 8'(s); odd_mode = odd;
        @(posedge clk); #1;
        sb.push_back('{res: r, nd: nd, cyc: cyc + n});
        nb = 0; got = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (t == 0) start = 1'b0;
            if (done) begin got = 1'b1; break; end
            if (busy) nb++;
        end
        check("done_seen", got, 1);
        check("busy_cycles", nb, n);
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int k;
        int cnt;
        #1_000_000;
        $display("FAIL watchdog_timeout actual=%0d required=0", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int cnt;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_num_digits", num_digits, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_one(123, 0, 1);
        run_one(123, 1, 1);
        run_one(7, 1, 1);
        run_one(0, 0, 1);
        run_one(255, 0, 1);
        run_one(10, 1, 1);
        run_one(10, 0, 1);

        // A start re-pulse during BUILD must be dropped.
        @(negedge clk);
        start = 1'b1; seed = 8'd200; odd_mode = 1'b0;
        @(posedge clk); #1;
        sb.push_back('{res: 200002, nd: 6, cyc: cyc + 3});
        @(negedge clk); start = 1'b1; seed = 8'd99; odd_mode = 1'b1;
        @(negedge clk); start = 1'b0;
        cnt = 0;
        while (sb.size() != 0 && cnt < 10) begin @(negedge clk); cnt++; end
        check("ignore_start_drained", sb.size(), 0);
        repeat (4) @(negedge clk);

        // start held high: the DONE edge accepts the next request.
        @(negedge clk);
        start = 1'b1; seed = 8'd123; odd_mode = 1'b0;
        @(posedge clk); #1;
        sb.push_back('{res: 123321, nd: 6, cyc: cyc + 3});
        @(negedge clk); seed = 8'd45; odd_mode = 1'b1;
        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        sb.push_back('{res: 454, nd: 3, cyc: cyc + 1});
        @(negedge clk); start = 1'b0;
        cnt = 0;
        while (sb.size() != 0 && cnt < 10) begin @(negedge clk); cnt++; end
        check("held_start_drained", sb.size(), 0);
        repeat (3) @(negedge clk);

        // Reset mid-BUILD aborts with no done pulse afterwards.
        @(negedge clk);
        start = 1'b1; seed = 8'd150; odd_mode = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        check("midrst_num_digits", num_digits, 0);
        @(negedge clk); rst_n = 1'b1;
        cnt = 0;
        for (int t = 0; t < 8; t++) begin @(negedge clk); if (done) cnt++; end
        check("no_done_after_reset", cnt, 0);

        for (int s = 0; s < 256; s++)
            for (int m = 0; m < 2; m++)
                run_one(s, m[0], int'($urandom_range(0, 2)));
        for (int i = 0; i < 40; i++)
            run_one(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
